lfsr_gen: RTL and testbench

Parametrised successor to the team's fixed 3-bit LFSR. It provides a W-bit linear feedback shift register with a configurable tap mask and runtime selection of Fibonacci or Galois form. It also supports seed loading, step enable, zero-seed lock-up protection and hardware period measurement. It serves as the pseudo-random source and self-test pattern generator in the lab datapath experiments.

---
 rtl/lfsr_pkg.sv | 21 ++
 rtl/lfsr_next.sv | 28 ++
 rtl/lfsr_gen.sv | 113 +++++++++++
 tb/tb_lfsr_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the parametrised LFSR generator.
// Default tap masks are maximal-length Fibonacci masks for common widths.
package lfsr_pkg;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

  localparam logic [2:0]  TAPS_W3  = 3'b110;
  localparam logic [3:0]  TAPS_W4  = 4'b1100;
  localparam logic [4:0]  TAPS_W5  = 5'b10100;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [31:0] TAPS_W32 = 32'h80200003;

  // Galois feedback mask for the same polynomial as a Fibonacci tap mask.
  // Callers keep only the low W bits of the result.
  function automatic logic [31:0] galois_mask(input logic [31:0] taps);
    return {taps[30:0], 1'b1};
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational single-step function of the LFSR in Fibonacci or Galois form.
// Both forms share one characteristic polynomial, so their periods match.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int unsigned    W    = 3,
  parameter logic [W-1:0]   TAPS = TAPS_W3
) (
  input  logic [W-1:0] q,
  input  logic         mode,
  output logic [W-1:0] q_next
);

  localparam logic [31:0]  G32 = galois_mask(32'(TAPS));
  localparam logic [W-1:0] G   = G32[W-1:0];

  logic         fb;
  logic [W-1:0] fib_next;
  logic [W-1:0] gal_next;

  always_comb begin
    fb       = ^(q & TAPS);
    fib_next = {q[W-2:0], fb};
    gal_next = {q[W-2:0], 1'b0} ^ (q[W-1] ? G : '0);
    q_next   = (mode == MODE_GAL) ? gal_next : fib_next;
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR with seed load, zero-seed protection, step counting
// and measurement of the cycle length back to the start state.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned  W     = 3,
  parameter logic [W-1:0] TAPS  = TAPS_W3,
  parameter logic [W-1:0] INIT  = 3'b001,
  parameter int unsigned  CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [W-1:0]     SEED,
  input  logic             MODE,
  output logic [W-1:0]     Q,
  output logic             SOUT,
  output logic             WRAP,
  output logic             LOCKUP,
  output logic [CNT_W-1:0] CNT,
  output logic [CNT_W-1:0] PERIOD
);

  if (W < 2 || W > 32) begin : g_bad_width
    $error("lfsr_gen: W must lie in 2..32");
  end
  if (TAPS[W-1] != 1'b1) begin : g_bad_taps
    $error("lfsr_gen: TAPS[W-1] must be set");
  end
  if (INIT == '0) begin : g_bad_init
    $error("lfsr_gen: INIT must be nonzero");
  end

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [W-1:0]     q_q,      q_d;
  logic [W-1:0]     start_q,  start_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             wrap_q,   wrap_d;
  logic             lockup_q, lockup_d;
  logic [W-1:0]     q_step;

  lfsr_next #(
    .W    (W),
    .TAPS (TAPS)
  ) u_next (
    .q      (q_q),
    .mode   (MODE),
    .q_next (q_step)
  );

  // LOAD outranks EN; pulses default low so they last exactly one cycle.
  always_comb begin
    q_d      = q_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    if (LOAD) begin
      cnt_d = '0;
      if (SEED != '0) begin
        q_d     = SEED;
        start_d = SEED;
      end else begin
        q_d      = INIT;
        start_d  = INIT;
        lockup_d = 1'b1;
      end
    end else if (EN) begin
      q_d = q_step;
      if (q_step == start_q) begin
        wrap_d   = 1'b1;
        period_d = sat_inc(cnt_q);
        cnt_d    = '0;
      end else begin
        cnt_d = sat_inc(cnt_q);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_q      <= INIT;
      start_q  <= INIT;
      cnt_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign Q      = q_q;
  assign SOUT   = q_q[W-1];
  assign WRAP   = wrap_q;
  assign LOCKUP = lockup_q;
  assign CNT    = cnt_q;
  assign PERIOD = period_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: 3-bit defaults (plus a narrow-counter copy)
// and an 8-bit maximal-length instance.
module tb_lfsr_gen;

  logic clk;
  int   n_cmp;
  int   n_bad;

  logic       rst, en, load, mode;
  logic [2:0] seed;
  logic [2:0] q3;
  logic       sout3, wrap3, lock3;
  logic [15:0] cnt3, per3;

  logic [2:0] qc;
  logic       soutc, wrapc, lockc;
  logic [1:0] cntc, perc;

  logic       rst8, en8, load8, mode8;
  logic [7:0] seed8, q8;
  logic       sout8, wrap8, lock8;
  logic [15:0] cnt8, per8;

  lfsr_gen dut3 (
    .CLK(clk), .RESET(rst), .EN(en), .LOAD(load), .SEED(seed), .MODE(mode),
    .Q(q3), .SOUT(sout3), .WRAP(wrap3), .LOCKUP(lock3), .CNT(cnt3), .PERIOD(per3)
  );

  lfsr_gen #(.CNT_W(2)) dutc (
    .CLK(clk), .RESET(rst), .EN(en), .LOAD(load), .SEED(seed), .MODE(mode),
    .Q(qc), .SOUT(soutc), .WRAP(wrapc), .LOCKUP(lockc), .CNT(cntc), .PERIOD(perc)
  );

  lfsr_gen #(.W(8), .TAPS(8'hB8), .INIT(8'h01), .CNT_W(16)) dut8 (
    .CLK(clk), .RESET(rst8), .EN(en8), .LOAD(load8), .SEED(seed8), .MODE(mode8),
    .Q(q8), .SOUT(sout8), .WRAP(wrap8), .LOCKUP(lock8), .CNT(cnt8), .PERIOD(per8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset3();
    rst = 1'b1; en = 1'b0; load = 1'b0; seed = 3'd0;
    tick(); tick();
    rst = 1'b0;
  endtask

  logic [2:0] fib_seq [7];
  logic [2:0] gal_seq [7];
  logic [2:0] s4_seq  [7];
  logic [7:0] b8_seq  [4];
  logic [2:0] s5_q    [4];
  logic [15:0] s5_cnt [4];
  logic       s5_en   [4];
  int         early_wraps;

  initial begin
    n_cmp = 0; n_bad = 0;
    fib_seq = '{3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b001};
    gal_seq = '{3'b010, 3'b100, 3'b101, 3'b111, 3'b011, 3'b110, 3'b001};
    s4_seq  = '{3'b011, 3'b111, 3'b110, 3'b100, 3'b001, 3'b010, 3'b101};
    b8_seq  = '{8'h02, 8'h04, 8'h08, 8'h11};
    s5_en   = '{1'b1, 1'b0, 1'b0, 1'b1};
    s5_q    = '{3'b010, 3'b010, 3'b010, 3'b101};
    s5_cnt  = '{16'd1, 16'd1, 16'd1, 16'd2};
    mode = 1'b0;
    rst8 = 1'b1; en8 = 1'b0; load8 = 1'b0; seed8 = 8'h00; mode8 = 1'b0;

    // reset state
    reset3();
    check_eq("rst_q", q3, 3'b001);
    check_eq("rst_sout", sout3, 1'b0);
    check_eq("rst_cnt", cnt3, 0);
    check_eq("rst_period", per3, 0);
    check_eq("rst_wrap", wrap3, 0);
    check_eq("rst_lockup", lock3, 0);

    // Fibonacci run, with saturating 2-bit counter copy
    en = 1'b1; mode = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      check_eq($sformatf("fib_q%0d", k), q3, fib_seq[k]);
      check_eq($sformatf("fib_wrap%0d", k), wrap3, (k == 6));
      check_eq($sformatf("fib_cnt%0d", k), cnt3, (k == 6) ? 0 : k + 1);
      check_eq($sformatf("sat_cnt%0d", k), cntc, (k == 6) ? 0 : ((k + 1 > 3) ? 3 : k + 1));
    end
    check_eq("fib_period", per3, 7);
    check_eq("sat_period", perc, 3);
    check_eq("fib_sout", sout3, 1'b0);

    // hold with EN low clears WRAP
    en = 1'b0;
    tick();
    check_eq("hold_q", q3, 3'b001);
    check_eq("hold_wrap", wrap3, 0);
    check_eq("hold_period", per3, 7);

    // zero seed lock-up protection
    load = 1'b1; seed = 3'b000;
    tick();
    check_eq("zs_q", q3, 3'b001);
    check_eq("zs_lockup", lock3, 1);
    check_eq("zs_cnt", cnt3, 0);
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k == 0) check_eq("zs_lockup_clr", lock3, 0);
      check_eq($sformatf("zs_wrap%0d", k), wrap3, (k == 6));
    end

    // Galois run
    reset3();
    en = 1'b1; mode = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      check_eq($sformatf("gal_q%0d", k), q3, gal_seq[k]);
      check_eq($sformatf("gal_wrap%0d", k), wrap3, (k == 6));
    end
    check_eq("gal_period", per3, 7);

    // LOAD with EN in the same cycle: load only
    reset3();
    mode = 1'b0;
    load = 1'b1; seed = 3'b101; en = 1'b1;
    tick();
    check_eq("ld_q", q3, 3'b101);
    check_eq("ld_cnt", cnt3, 0);
    check_eq("ld_lockup", lock3, 0);
    load = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      check_eq($sformatf("ld_q%0d", k), q3, s4_seq[k]);
      check_eq($sformatf("ld_wrap%0d", k), wrap3, (k == 6));
    end
    check_eq("ld_period", per3, 7);

    // EN toggling 1,0,0,1
    reset3();
    for (int k = 0; k < 4; k++) begin
      en = s5_en[k];
      tick();
      check_eq($sformatf("tog_q%0d", k), q3, s5_q[k]);
      check_eq($sformatf("tog_cnt%0d", k), cnt3, s5_cnt[k]);
    end

    // RESET outranks LOAD
    rst = 1'b1; load = 1'b1; seed = 3'b110; en = 1'b1;
    tick();
    check_eq("rstpri_q", q3, 3'b001);
    check_eq("rstpri_cnt", cnt3, 0);
    rst = 1'b0; load = 1'b0; en = 1'b0;

    // 8-bit maximal-length run
    tick(); tick();
    rst8 = 1'b0; en8 = 1'b1;
    early_wraps = 0;
    for (int s = 1; s <= 255; s++) begin
      tick();
      if (s <= 4) check_eq($sformatf("w8_q%0d", s), q8, b8_seq[s-1]);
      if (s < 255 && wrap8) early_wraps++;
    end
    check_eq("w8_early_wraps", early_wraps, 0);
    check_eq("w8_wrap", wrap8, 1);
    check_eq("w8_period", per8, 255);
    check_eq("w8_q_back", q8, 8'h01);
    check_eq("w8_cnt", cnt8, 0);
    for (int s = 1; s <= 100; s++) tick();
    check_eq("w8_cnt100", cnt8, 100);
    rst8 = 1'b1;
    tick();
    check_eq("w8_rst_q", q8, 8'h01);
    check_eq("w8_rst_cnt", cnt8, 0);
    check_eq("w8_rst_period", per8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
